// File: rtl/score_life_ctrl_pkg.sv
// Shared encodings and helpers for the score/life controller and its BCD sequencer.
package score_life_ctrl_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned LIFE_W  = 3;
  localparam int unsigned THERM_W = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  // Thermometer code: the lowest n bits set.
  function automatic logic [THERM_W-1:0] life_therm(input logic [LIFE_W-1:0] n);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < int'(THERM_W); i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

  // Double-dabble correction applied to a digit before each shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    return (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
  endfunction

endpackage

// File: rtl/score_life_ctrl_bin2bcd_seq.sv
// Multi-cycle shift/add-3 binary-to-BCD converter; digits update atomically on done.
module bin2bcd_seq
  import score_life_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   d2,
  output logic [BCD_W-1:0]   d1,
  output logic [BCD_W-1:0]   d0
);

  localparam int unsigned SR_W  = 3 * BCD_W + SCORE_W;
  localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;
  logic             active;

  // One double-dabble iteration: correct the three digit fields, then shift.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 3; k++) begin
      sr_adj[SCORE_W + k*BCD_W +: BCD_W] = add3(sr[SCORE_W + k*BCD_W +: BCD_W]);
    end
  end

  // busy spans load through the done cycle so a rerun starts the cycle after done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d2     <= '0;
      d1     <= '0;
      d0     <= '0;
    end else begin
      done <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      if (go && !busy) begin
        sr     <= {(3*BCD_W)'(0), bin};
        cnt    <= CNT_W'(SCORE_W);
        active <= 1'b1;
        busy   <= 1'b1;
      end else if (active) begin
        if (cnt != '0) begin
          sr  <= {sr_adj[SR_W-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
        end else begin
          d2     <= sr[SCORE_W + 2*BCD_W +: BCD_W];
          d1     <= sr[SCORE_W + BCD_W +: BCD_W];
          d0     <= sr[SCORE_W +: BCD_W];
          done   <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/score_life_ctrl.sv
// Game-state controller: owns score and lives, requests BCD conversions of the score.
module score_life_ctrl
  import score_life_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W    = 10,
  parameter int unsigned MAX_SCORE  = 999,
  parameter int unsigned HIT_PTS    = 5,
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] fenshu,
  output logic [2:0]         life,
  output logic [6:0]         shengming,
  output logic [3:0]         fenshu2,
  output logic [3:0]         fenshu1,
  output logic [3:0]         fenshu0,
  output logic               bcd_valid,
  output logic               playing,
  output logic               game_over
);

  localparam int unsigned SUM_W = SCORE_W + 1;

  logic [1:0]         state, state_nxt;
  logic [SCORE_W-1:0] fenshu_nxt;
  logic [LIFE_W-1:0]  life_nxt;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] capped;
  logic               req_q, req_nxt;
  logic               pending, pending_nxt;
  logic               conv_go_c;
  logic               conv_busy;

  // Next-state, score/life update and conversion request generation.
  always_comb begin
    state_nxt  = state;
    fenshu_nxt = fenshu;
    life_nxt   = life;
    req_nxt    = 1'b0;
    sum        = {1'b0, fenshu} + SUM_W'(HIT_PTS);
    capped     = (sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    case (state)
      ST_PLAY: begin
        if (hit) begin
          fenshu_nxt = capped;
        end
        if (miss) begin
          life_nxt = life - LIFE_W'(1);
          if (life == LIFE_W'(1)) begin
            state_nxt = ST_OVER;
          end
        end
      end
      default: begin
        if (start) begin
          state_nxt  = ST_PLAY;
          fenshu_nxt = '0;
          life_nxt   = LIFE_W'(LIVES_INIT);
          req_nxt    = 1'b1;
        end
      end
    endcase
    if (fenshu_nxt != fenshu) begin
      req_nxt = 1'b1;
    end
  end

  // Requests arriving while the converter is busy coalesce into one rerun.
  assign conv_go_c   = (req_q || pending) && !conv_busy;
  assign pending_nxt = (req_q || pending) && conv_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fenshu    <= '0;
      life      <= '0;
      shengming <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      req_q     <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      fenshu    <= fenshu_nxt;
      life      <= life_nxt;
      shengming <= life_therm(life_nxt);
      playing   <= (state_nxt == ST_PLAY);
      game_over <= (state_nxt == ST_OVER);
      req_q     <= req_nxt;
      pending   <= pending_nxt;
    end
  end

  bin2bcd_seq #(
    .SCORE_W(SCORE_W)
  ) u_bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (conv_go_c),
    .bin  (fenshu),
    .busy (conv_busy),
    .done (bcd_valid),
    .d2   (fenshu2),
    .d1   (fenshu1),
    .d0   (fenshu0)
  );

endmodule

// File: tb/tb_score_life_ctrl.sv
// Randomized scoreboard bench for score_life_ctrl against a behavioural game model.
module tb_score_life_ctrl;

  localparam int SCORE_W = 10;
  localparam int MAXS    = 999;
  localparam int PTS     = 5;
  localparam int LI      = 3;
  localparam int LAT     = SCORE_W + 3;

  logic               clk = 1'b0;
  logic               rst_n, start, hit, miss;
  logic [SCORE_W-1:0] fenshu;
  logic [2:0]         life;
  logic [6:0]         shengming;
  logic [3:0]         fenshu2, fenshu1, fenshu0;
  logic               bcd_valid, playing, game_over;

  score_life_ctrl #(
    .SCORE_W(SCORE_W), .MAX_SCORE(MAXS), .HIT_PTS(PTS), .LIVES_INIT(LI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .miss(miss),
    .fenshu(fenshu), .life(life), .shengming(shengming),
    .fenshu2(fenshu2), .fenshu1(fenshu1), .fenshu0(fenshu0),
    .bcd_valid(bcd_valid), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  // Game model
  int m_score = 0, m_life = 0, shown = 0;
  bit m_play = 1'b0, m_over = 1'b0;
  // Conversion timing model: one result at a time, latest score wins on rerun
  bit c_busy = 1'b0, c_pend = 1'b0;
  int c_done_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rn, input bit s, input bit h, input bit m);
    bit ev;
    int ns;
    rst_n = rn; start = s; hit = h; miss = m;
    @(posedge clk);
    cyc++;
    ev = 1'b0;
    if (!rn) begin
      m_score = 0; m_life = 0; m_play = 1'b0; m_over = 1'b0;
      shown = 0; c_busy = 1'b0; c_pend = 1'b0;
      q.delete();
    end else begin
      if (!m_play) begin
        if (s) begin
          m_play = 1'b1; m_over = 1'b0; m_score = 0; m_life = LI; ev = 1'b1;
        end
      end else begin
        if (h) begin
          ns = (m_score + PTS > MAXS) ? MAXS : m_score + PTS;
          if (ns != m_score) ev = 1'b1;
          m_score = ns;
        end
        if (m) begin
          m_life--;
          if (m_life == 0) begin
            m_play = 1'b0; m_over = 1'b1;
          end
        end
      end
      if (c_busy && cyc > c_done_cyc) c_busy = 1'b0;
      if (ev || c_pend) begin
        if (!c_busy) begin
          q.push_back('{cyc + LAT - 1, m_score});
          c_busy = 1'b1; c_done_cyc = cyc + LAT - 1; c_pend = 1'b0;
        end else begin
          c_pend = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle register checks plus scoreboard pop on bcd_valid
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("fenshu", int'(fenshu), m_score);
      chk("life", int'(life), m_life);
      chk("shengming", int'(shengming), (1 << m_life) - 1);
      chk("playing", int'(playing), int'(m_play));
      chk("game_over", int'(game_over), int'(m_over));
      if (bcd_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_bcd_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bcd_valid_cycle", cyc, e.cyc);
          chk("digits_on_valid", int'(fenshu2) * 100 + int'(fenshu1) * 10 + int'(fenshu0), e.val);
          shown = e.val;
        end
      end else begin
        chk("digits_stable", int'(fenshu2) * 100 + int'(fenshu1) * 10 + int'(fenshu0), shown);
      end
    end
  end

  initial begin
    int r;
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    idle(4);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("idle_hit_ignored", int'(fenshu), 0);

    // Start and three spaced hits
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(19);
    end
    chk("score_15", int'(fenshu), 15);

    // Back-to-back hits after quiet period: two conversions, the rerun coalesced
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(40);
    chk("score_25", int'(fenshu), 25);

    // Climb to 995 with random gaps, then saturate
    while (m_score < 995) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(30);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("score_sat", int'(fenshu), 999);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("score_still_sat", int'(fenshu), 999);

    // Lose all lives, then events ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
    end
    chk("over_flag", int'(game_over), 1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Restart from OVER, reset mid-conversion, fresh start
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_life", int'(life), 0);
    idle(20);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("fresh_life", int'(life), 3);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      step(r >= 4, r >= 4 && r < 40, r >= 100 && r < 420, r >= 400 && r < 460);
    end
    idle(40);
    chk("drain_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
